// File: rtl/conv_window_ctrl.sv
// Streams a binary image in raster order through K-1 line buffers and a K x K window,
// presenting each valid window to an external mac and returning its sum over valid/ready.
module conv_window_ctrl #(
    parameter int K     = 3,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    localparam int RW   = $clog2(IMG_H),
    localparam int CW   = $clog2(IMG_W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic            in_pixel,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [K*K-1:0]  mac_img,
    input  logic [31:0]     mac_sum,
    output logic [31:0]     out_sum,
    output logic [RW-1:0]   out_row,
    output logic [CW-1:0]   out_col,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int N  = K * K;
    localparam int LB = (K - 1) * IMG_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d, out_row_q, out_row_d;
    logic [CW-1:0]   col_q, col_d, out_col_q, out_col_d;
    logic            all_acc_q, all_acc_d;
    logic            out_valid_q, out_valid_d;
    logic            done_q, done_d;
    logic [LB-1:0]   lb_q, lb_d;
    logic [N-1:0]    win_q, win_d, mac_img_q, mac_img_d;
    logic [N-1:0]    win_next;
    logic            accept, result_hs, last_hs, emit;

    // NOTE: in_ready is combinational so a stalled result blocks the pixel in the same cycle.
    assign in_ready  = (state_q == RUN) & ~(out_valid_q & ~out_ready) & ~all_acc_q;
    assign accept    = in_valid & in_ready;
    assign result_hs = out_valid_q & out_ready;
    assign last_hs   = result_hs && (out_row_q == RW'(IMG_H - K)) && (out_col_q == CW'(IMG_W - K));
    assign emit      = accept && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));

    // Row-major window with bit N-1 top-left: shifting one column left is a plain
    // left shift, then the right column (bits d*K, d rows above the bottom) is refilled.
    always_comb begin
        win_next    = win_q << 1;
        win_next[0] = in_pixel;
        for (int d = 1; d < K; d++) begin
            win_next[d*K] = lb_q[d*IMG_W-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        all_acc_d   = all_acc_q;
        lb_d        = lb_q;
        win_d       = win_q;
        mac_img_d   = mac_img_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_valid_d = out_valid_q;
        done_d      = last_hs;

        if (state_q == IDLE) begin
            if (start) begin
                state_d   = RUN;
                row_d     = '0;
                col_d     = '0;
                all_acc_d = 1'b0;
            end
        end else if (last_hs) begin
            state_d = IDLE;
        end

        if (accept) begin
            lb_d  = {lb_q[LB-2:0], in_pixel};
            win_d = win_next;
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                if (row_q == RW'(IMG_H - 1)) begin
                    row_d     = '0;
                    all_acc_d = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (emit) begin
            mac_img_d   = win_next;
            out_row_d   = row_q - RW'(K - 1);
            out_col_d   = col_q - CW'(K - 1);
            out_valid_d = 1'b1;
        end else if (result_hs) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: line buffers and window are reset along with control state so a frame
    // started after reset never depends on pixels from an aborted one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            all_acc_q   <= 1'b0;
            lb_q        <= '0;
            win_q       <= '0;
            mac_img_q   <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            all_acc_q   <= all_acc_d;
            lb_q        <= lb_d;
            win_q       <= win_d;
            mac_img_q   <= mac_img_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign mac_img   = mac_img_q;
    assign out_sum   = mac_sum;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl on a 5x5 image with a 3x3 mac (kernel 101_010_101);
// expected windows and sums are computed directly from each frame's pixel array.
module tb_conv_window_ctrl;

    localparam int K  = 3;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int NP = W * H;
    localparam int NR = (H - K + 1) * (W - K + 1);
    localparam int RW = $clog2(H);
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst, start, in_pixel, in_valid, out_ready;
    logic          busy, done, in_ready, out_valid;
    logic [K*K-1:0] mac_img;
    logic [31:0]   mac_sum, out_sum;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;

    always #5 clk = ~clk;

    conv_window_ctrl #(.K(K), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
        .mac_img(mac_img), .mac_sum(mac_sum), .out_sum(out_sum),
        .out_row(out_row), .out_col(out_col), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // External mac: popcount of the patch masked by kernel 101_010_101.
    assign mac_sum = 32'($countones(mac_img & 9'b101010101));

    typedef struct {
        logic [31:0]    sum;
        logic [K*K-1:0] patch;
        int             r;
        int             c;
    } res_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   img [NP];
    res_t exp_q [$];

    // Reference: enumerate window positions in raster order and evaluate each from the image.
    function automatic void build_expected();
        res_t e;
        exp_q.delete();
        for (int wr = 0; wr <= H - K; wr++) begin
            for (int wc = 0; wc <= W - K; wc++) begin
                e.sum   = 0;
                e.patch = '0;
                e.r     = wr;
                e.c     = wc;
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        bit b;
                        b = img[(wr + i) * W + wc + j];
                        e.patch[K*K-1-(i*K+j)] = b;
                        if (b && ((i * K + j) % 2 == 0)) e.sum = e.sum + 1;
                    end
                end
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic do_start();
        @(negedge clk);
        start     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_after_start: got %b expected 1", busy);
        end
    endtask

    // mode 0: full rate, 1: random gaps and random out_ready, 2: full rate with a
    // 3-cycle stall on the 2nd result. start_at >= 0 pulses start mid-frame.
    task automatic run_frame(input string name, input int mode, input int start_at);
        int             pix = 0, got = 0, dones = 0, stalls = 0;
        int             first_valid = -1, acc12 = -1;
        bit             finished = 0;
        logic [K*K-1:0] hold_img;
        logic [RW-1:0]  hold_r;
        logic [CW-1:0]  hold_c;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            start    = (cyc == start_at);
            in_valid = (pix < NP) && (mode != 1 || $urandom_range(3) != 0);
            in_pixel = 1'b0;
            if (pix < NP) in_pixel = img[pix];
            if (mode == 2 && out_valid && got == 1 && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else if (mode == 1) begin
                out_ready = ($urandom_range(2) != 0);
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (pix == NP) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s in_ready_after_frame: got %b expected 0", name, in_ready);
                end
            end
            if (mode == 2 && out_valid && !out_ready) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s in_ready_stall: got %b expected 0", name, in_ready);
                end
                if (stalls == 1) begin
                    hold_img = mac_img;
                    hold_r   = out_row;
                    hold_c   = out_col;
                end else begin
                    n_cmp++;
                    if ({mac_img, out_row, out_col} !== {hold_img, hold_r, hold_c}) begin
                        n_bad++;
                        $display("FAIL %s stall_stable: got %h/%0d/%0d expected %h/%0d/%0d",
                                 name, mac_img, out_row, out_col, hold_img, hold_r, hold_c);
                    end
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (got >= NR) begin
                    n_bad++;
                    $display("FAIL %s extra_result: got result #%0d expected at most %0d", name, got + 1, NR);
                end else if (out_sum !== exp_q[got].sum || mac_img !== exp_q[got].patch ||
                             out_row !== RW'(exp_q[got].r) || out_col !== CW'(exp_q[got].c)) begin
                    n_bad++;
                    $display("FAIL %s result%0d: got sum=%0d img=%b at (%0d,%0d) expected sum=%0d img=%b at (%0d,%0d)",
                             name, got, out_sum, mac_img, out_row, out_col,
                             exp_q[got].sum, exp_q[got].patch, exp_q[got].r, exp_q[got].c);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                if (pix == 2 * W + 2) acc12 = cyc;
                pix++;
            end
            if (done) begin
                dones++;
                finished = 1;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (!finished || got != NR || dones != 1 || pix != NP) begin
            n_bad++;
            $display("FAIL %s frame_totals: got results=%0d done=%0d pixels=%0d expected %0d/1/%0d",
                     name, got, dones, pix, NR, NP);
        end
        if (mode == 0) begin
            n_cmp++;
            if (first_valid != acc12 + 1) begin
                n_bad++;
                $display("FAIL %s first_valid_latency: got cycle %0d expected %0d", name, first_valid, acc12 + 1);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after_done: got done=%b busy=%b expected 0/0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, in_ready, out_valid, mac_img, out_row, out_col} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got %b%b%b%b img=%b (%0d,%0d) expected all zero",
                     busy, done, in_ready, out_valid, mac_img, out_row, out_col);
        end
        rst = 1'b0;
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < NP; i++) img[i] = 1'b1;
        build_expected();
        do_start();
        run_frame("all_ones", 0, -1);
    endtask

    task automatic test_checkerboard();
        for (int i = 0; i < NP; i++) img[i] = ((i / W + i % W) % 2 == 0);
        build_expected();
        do_start();
        run_frame("checker", 0, -1);
    endtask

    task automatic test_single_pixel();
        for (int i = 0; i < NP; i++) img[i] = 1'b0;
        img[2 * W + 2] = 1'b1;
        build_expected();
        do_start();
        run_frame("single", 1, -1);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < NP; i++) img[i] = bit'($urandom_range(1));
        build_expected();
        do_start();
        run_frame("backpressure", 2, -1);
    endtask

    task automatic test_reset_mid_frame();
        do_start();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_pixel  = bit'($urandom_range(1));
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, in_ready, out_valid, mac_img, out_row, out_col} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_state: got %b%b%b%b img=%b (%0d,%0d) expected all zero",
                     busy, done, in_ready, out_valid, mac_img, out_row, out_col);
        end
        for (int i = 0; i < NP; i++) img[i] = bit'($urandom_range(1));
        build_expected();
        do_start();
        run_frame("after_reset", 1, -1);
    endtask

    task automatic test_start_during_run();
        for (int i = 0; i < NP; i++) img[i] = bit'($urandom_range(1));
        build_expected();
        do_start();
        run_frame("start_in_run", 1, 6);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_checkerboard();
        test_single_pixel();
        test_backpressure();
        test_reset_mid_frame();
        test_start_during_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
